// File: rtl/uart_rx_bram_writer_if.sv
// Bus bundle for the UART receive / BRAM write path.
// master: the receiver (drives BRAM port and byte strobe).
// slave : the consumer side (drives rx line and pointer clear).
interface uart_rx_bram_writer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx;
  logic                  addr_clr;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  busy;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [7:0]            bram_din;

  modport master (
    input  rx, addr_clr,
    output rx_data, rx_valid, frame_err, busy, bram_we, bram_addr, bram_din
  );

  modport slave (
    output rx, addr_clr,
    input  rx_data, rx_valid, frame_err, busy, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/uart_rx_bram_writer.sv
// 8N1 UART receiver that writes each good byte into a BRAM write port
// at a self-incrementing, wrapping address and strobes it out as well.
module uart_rx_bram_writer #(
  parameter int CLKS_PER_BIT = 278,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic clk,
  input  logic rst,
  uart_rx_bram_writer_if.master bus
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_TERM = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                state;
  logic                  rx_q1, rx_s;
  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic [7:0]            shreg;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] wptr;
  logic                  tick;

  assign tick = (cnt == CNT_TERM);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= bus.rx;
      rx_s  <= rx_q1;
    end
  end

  // Frame deserializer FSM with registered strobes and byte output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      bram_we   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      bram_we   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Half a bit after the falling edge: recheck to reject glitches.
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              bram_we  <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // Break or bad stop: hold off until the line returns high.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write pointer: advance after each write; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               wptr <= '0;
    else if (bus.addr_clr) wptr <= '0;
    else if (bram_we)      wptr <= wptr + 1'b1;
  end

  assign bus.rx_data   = rx_data;
  assign bus.bram_din  = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.bram_we   = bram_we;
  assign bus.frame_err = frame_err;
  assign bus.bram_addr = wptr;
  assign bus.busy      = (state != IDLE);

endmodule
